mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the Risc_16_bit instruction fetch (IF) and memory stage (DM).
- Sits between the pipeline and the memory, and sequences each access through a request/ack handshake.
- Absorbs variable memory wait states and raises a per-requester ack that the pipeline uses as its stall release.
- Data port has priority, bounded by a fetch starvation limit; a per-access wait timeout prevents lockup.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data word width.
- STARVE_LIMIT, 4, consecutive DM grants allowed while if_req is pending; the next contested grant goes to IF.
- TIMEOUT, 15, max cycles mem_req waits for mem_ready before the access is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse to IF.
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; valid while dm_ack=1.
- dm_ack  out  1  one-cycle completion pulse to DM.
- mem_req  out  1  access strobe to memory.
- mem_we  out  1  write enable to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ready.
- mem_ready  in  1  memory completes the current access this cycle.
- owner  out  2  0 = none, 1 = IF, 2 = DM.
- bus_err  out  1  sticky flag: a timeout has occurred.

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM in IDLE; starve_cnt = 0; wait_cnt = 0.
- FSM states: IDLE, BUSY_IF, BUSY_DM. All outputs are registered.
- IDLE arbitration, evaluated each cycle:
  - Eligible = req high AND that requester's ack is not high this cycle. This blocks regrant on the ack cycle, before the requester drops req.
  - Only one eligible: grant it.
  - Both eligible: grant DM, unless starve_cnt == STARVE_LIMIT, then grant IF.
  - On grant: next cycle mem_req=1, mem_addr/mem_we/mem_wdata are latched from the winner, owner is set, and the FSM moves to BUSY_x.
  - IF accesses always drive mem_we=0.
- starve_cnt:
  - Increments (saturating) on each DM grant made while if_req=1.
  - Clears on any IF grant.
  - Clears on a DM grant made with if_req=0.
- BUSY_x:
  - mem_req and the latched fields are held constant.
  - wait_cnt increments each cycle that mem_ready=0.
  - mem_ready=1: next cycle x_ack=1 for exactly 1 cycle, x_rdata=mem_rdata (loads; stores also capture mem_rdata, which DM ignores), mem_req=0, owner=0, FSM goes to IDLE, wait_cnt cleared.
  - wait_cnt reaching TIMEOUT with mem_ready=0: next cycle x_ack=1, x_rdata=0, bus_err=1 (sticky until rst), mem_req=0, FSM goes to IDLE.
  - mem_ready in the same cycle as the timeout: the ready path wins and there is no error.
- Timing:
  - Minimum latency, req to ack, is 3 cycles: grant, memory ready in the first busy cycle, ack.
  - Throughput is one access per 3 cycles.
- mem_ready while in IDLE is ignored.
- rx_rdata outputs hold their value after ack until the next ack.
- rst mid-access: FSM goes to IDLE and mem_req=0 next cycle. No ack is issued, and the requester re-requests. bus_err clears.
- Requester protocol violations (dropping req before ack) are not supported. The latched access completes normally and its ack is still issued.

Decomposition:
- Package risc_mem_pkg holds:
  - ADDR_W/DATA_W defaults.
  - State enum (IDLE/BUSY_IF/BUSY_DM).
  - Owner encoding constants OWN_NONE=0, OWN_IF=1, OWN_DM=2.
- One sub-module: mem_wait_timer (wait_cnt, clear/enable, timeout pulse at TIMEOUT).
- Arbitration and starve_cnt stay inline.

Test Plan:
- IF only, if_addr=0x0010, memory ready after 0 waits, mem_rdata=0xA5A5 -> mem_req high for 1 cycle with mem_addr=0x0010, if_ack pulse at cycle 3, if_rdata=0xA5A5, owner back to 0.
- Simultaneous if_req and dm_req (load 0x0200, ready after 2 waits, data 0x1234) -> DM granted first, dm_ack with 0x1234; IF granted next IDLE, if_ack follows; no double grant on the ack cycles.
- Store dm_we=1, dm_addr=0x0300, dm_wdata=0xBEEF -> mem_we=1, mem_wdata=0xBEEF, mem_addr=0x0300 held until mem_ready; if_ack never pulses.
- dm_req held continuously (5 back-to-back DM transactions) with if_req pending -> grants DM×4, then IF on the 5th contested arbitration; starve_cnt returns to 0.
- mem_ready held low -> after TIMEOUT=15 wait cycles, x_ack pulse with rdata=0x0000 and bus_err=1. A subsequent good access completes; bus_err stays 1 until rst.
- rst asserted in the 2nd cycle of BUSY_IF -> next cycle mem_req=0, owner=0, no if_ack. A re-request after rst completes normally.

Source files
------------

// File: rtl/risc_mem_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
// Owner encoding is derived from the FSM state so the two can never disagree.
package risc_mem_pkg;

    localparam int ADDR_W_DEFAULT = 16;
    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_DM   = 2'd2;

    function automatic logic [1:0] owner_of(input arb_state_t st);
        logic [1:0] own;
        case (st)
            BUSY_IF: own = OWN_IF;
            BUSY_DM: own = OWN_DM;
            default: own = OWN_NONE;
        endcase
        return own;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Counts memory wait cycles of the current access and flags the cycle in
// which the TIMEOUT-th consecutive wait occurs.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt_r;

    assign timeout = en && (wait_cnt_r == LAST);

    // wait counter: cleared between accesses, advanced on each stalled cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (en && !timeout) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the data
// stage: DM has priority, IF is forced through after STARVE_LIMIT DM wins.
module mem_port_arbiter
    import risc_mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEFAULT,
    parameter int DATA_W       = DATA_W_DEFAULT,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        owner,
    output logic              bus_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t        state_r, state_n;
    logic [SW-1:0]     starve_r, starve_n;
    logic              mem_req_r, mem_req_n, mem_we_r, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_n;
    logic              if_ack_r, if_ack_n, dm_ack_r, dm_ack_n;
    logic [DATA_W-1:0] if_rdata_r, if_rdata_n, dm_rdata_r, dm_rdata_n;
    logic [1:0]        owner_r;
    logic              bus_err_r, bus_err_n;

    logic              if_elig_s, dm_elig_s, grant_if_s, grant_dm_s;
    logic              busy_s, timeout_s, done_s;
    logic [DATA_W-1:0] done_data_s;

    // A requester is not eligible in its own ack cycle: its req is still high
    // there but belongs to the access that just completed.
    assign if_elig_s   = if_req && !if_ack_r;
    assign dm_elig_s   = dm_req && !dm_ack_r;
    assign grant_if_s  = (state_r == IDLE) && if_elig_s &&
                         (!dm_elig_s || (starve_r == STARVE_MAX));
    assign grant_dm_s  = (state_r == IDLE) && dm_elig_s && !grant_if_s;
    assign busy_s      = (state_r == BUSY_IF) || (state_r == BUSY_DM);
    assign done_s      = busy_s && (mem_ready || timeout_s);
    assign done_data_s = mem_ready ? mem_rdata : {DATA_W{1'b0}};

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!busy_s || mem_ready),
        .en      (busy_s && !mem_ready),
        .timeout (timeout_s)
    );

    // next-state, grant and completion decode
    always_comb begin
        state_n     = state_r;
        starve_n    = starve_r;
        mem_req_n   = mem_req_r;
        mem_we_n    = mem_we_r;
        mem_addr_n  = mem_addr_r;
        mem_wdata_n = mem_wdata_r;
        if_ack_n    = 1'b0;
        dm_ack_n    = 1'b0;
        if_rdata_n  = if_rdata_r;
        dm_rdata_n  = dm_rdata_r;
        bus_err_n   = bus_err_r;
        case (state_r)
            IDLE: begin
                if (grant_if_s) begin
                    state_n     = BUSY_IF;
                    mem_req_n   = 1'b1;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = if_addr;
                    mem_wdata_n = {DATA_W{1'b0}};
                    starve_n    = {SW{1'b0}};
                end else if (grant_dm_s) begin
                    state_n     = BUSY_DM;
                    mem_req_n   = 1'b1;
                    mem_we_n    = dm_we;
                    mem_addr_n  = dm_addr;
                    mem_wdata_n = dm_wdata;
                    if (!if_req) begin
                        starve_n = {SW{1'b0}};
                    end else if (starve_r == STARVE_MAX) begin
                        starve_n = starve_r;
                    end else begin
                        starve_n = starve_r + SW'(1);
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (done_s) begin
                    state_n   = IDLE;
                    mem_req_n = 1'b0;
                    if (state_r == BUSY_IF) begin
                        if_ack_n   = 1'b1;
                        if_rdata_n = done_data_s;
                    end else begin
                        dm_ack_n   = 1'b1;
                        dm_rdata_n = done_data_s;
                    end
                    if (!mem_ready) begin
                        bus_err_n = 1'b1;
                    end else begin
                        bus_err_n = bus_err_r;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            default: begin
                state_n   = IDLE;
                mem_req_n = 1'b0;
            end
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            starve_r    <= {SW{1'b0}};
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            if_ack_r    <= 1'b0;
            dm_ack_r    <= 1'b0;
            if_rdata_r  <= {DATA_W{1'b0}};
            dm_rdata_r  <= {DATA_W{1'b0}};
            owner_r     <= OWN_NONE;
            bus_err_r   <= 1'b0;
        end else begin
            state_r     <= state_n;
            starve_r    <= starve_n;
            mem_req_r   <= mem_req_n;
            mem_we_r    <= mem_we_n;
            mem_addr_r  <= mem_addr_n;
            mem_wdata_r <= mem_wdata_n;
            if_ack_r    <= if_ack_n;
            dm_ack_r    <= dm_ack_n;
            if_rdata_r  <= if_rdata_n;
            dm_rdata_r  <= dm_rdata_n;
            owner_r     <= owner_of(state_n);
            bus_err_r   <= bus_err_n;
        end
    end

    assign if_rdata  = if_rdata_r;
    assign if_ack    = if_ack_r;
    assign dm_rdata  = dm_rdata_r;
    assign dm_ack    = dm_ack_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign owner     = owner_r;
    assign bus_err   = bus_err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random
// soak, all checked against a transaction-level reference model.
module tb_mem_port_arbiter;
    import risc_mem_pkg::*;

    localparam int SL = 4;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst, if_req, dm_req, dm_we, mem_ready;
    logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ack, dm_ack, mem_req, mem_we, bus_err;
    logic [1:0]  owner;

    int total = 0;
    int bad   = 0;

    // reference model: who holds the memory, waits so far, starvation count
    logic [1:0]  m_hold;
    int          m_wait, m_starve;
    logic        m_bus_err, m_mem_req, m_we, m_if_ack, m_dm_ack;
    logic [15:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner), .bus_err(bus_err)
    );

    function automatic logic [70:0] dut_vec();
        return {if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata, owner, bus_err};
    endfunction

    function automatic logic [70:0] mdl_vec();
        return {m_if_ack, m_if_rdata, m_dm_ack, m_dm_rdata, m_mem_req, m_we, m_addr, m_wdata, m_hold, m_bus_err};
    endfunction

    task automatic model_reset();
        m_hold = 2'd0; m_wait = 0; m_starve = 0; m_bus_err = 1'b0; m_mem_req = 1'b0;
        m_we = 1'b0; m_if_ack = 1'b0; m_dm_ack = 1'b0; m_addr = 16'h0; m_wdata = 16'h0;
        m_if_rdata = 16'h0; m_dm_rdata = 16'h0;
    endtask

    // advance the model by one clock on the current inputs, then the DUT
    task automatic step();
        logic        ife, dme;
        logic [15:0] d;
        if (rst) begin
            model_reset();
        end else begin
            ife = if_req && !m_if_ack;
            dme = dm_req && !m_dm_ack;
            m_if_ack = 1'b0;
            m_dm_ack = 1'b0;
            if (m_hold == 2'd0) begin
                if (ife && (!dme || m_starve == SL)) begin
                    m_hold = 2'd1; m_mem_req = 1'b1; m_we = 1'b0;
                    m_addr = if_addr; m_wdata = 16'h0; m_starve = 0;
                end else if (dme) begin
                    m_hold = 2'd2; m_mem_req = 1'b1; m_we = dm_we;
                    m_addr = dm_addr; m_wdata = dm_wdata;
                    m_starve = if_req ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
                end
            end else if (mem_ready || (m_wait + 1 == TO)) begin
                d = mem_ready ? mem_rdata : 16'h0;
                if (!mem_ready) m_bus_err = 1'b1;
                if (m_hold == 2'd1) begin m_if_ack = 1'b1; m_if_rdata = d; end
                else begin m_dm_ack = 1'b1; m_dm_rdata = d; end
                m_hold = 2'd0; m_mem_req = 1'b0; m_wait = 0;
            end else begin
                m_wait = m_wait + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if (dut_vec() !== 71'h0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", dut_vec());
        end
        rst = 1'b0;
    endtask

    task automatic test_if_only();
        mem_ready = 1'b1; mem_rdata = 16'hA5A5;
        if_req = 1'b1; if_addr = 16'h0010;
        step();
        total++;
        if ({mem_req, mem_addr, owner, if_ack} !== {1'b1, 16'h0010, OWN_IF, 1'b0}) begin
            bad++; $display("FAIL if_grant: got %h want %h", {mem_req, mem_addr, owner, if_ack}, {1'b1, 16'h0010, OWN_IF, 1'b0});
        end
        step();
        total++;
        if ({if_ack, if_rdata, mem_req, owner} !== {1'b1, 16'hA5A5, 1'b0, OWN_NONE}) begin
            bad++; $display("FAIL if_ack: got %h want %h", {if_ack, if_rdata, mem_req, owner}, {1'b1, 16'hA5A5, 1'b0, OWN_NONE});
        end
        if_req = 1'b0;
        step();
        total++;
        if ({if_ack, mem_req, if_rdata} !== {1'b0, 1'b0, 16'hA5A5}) begin
            bad++; $display("FAIL if_after_ack: got %h want %h", {if_ack, mem_req, if_rdata}, {1'b0, 1'b0, 16'hA5A5});
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_contend();
        if_req = 1'b1; if_addr = 16'h0040;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0200; dm_wdata = 16'h0;
        step();
        total++;
        if ({owner, mem_addr, mem_we} !== {OWN_DM, 16'h0200, 1'b0}) begin
            bad++; $display("FAIL contend_dm_first: got %h want %h", {owner, mem_addr, mem_we}, {OWN_DM, 16'h0200, 1'b0});
        end
        step();
        step();
        mem_ready = 1'b1; mem_rdata = 16'h1234;
        step();
        total++;
        if ({dm_ack, dm_rdata, owner, if_ack} !== {1'b1, 16'h1234, OWN_NONE, 1'b0}) begin
            bad++; $display("FAIL contend_dm_ack: got %h want %h", {dm_ack, dm_rdata, owner, if_ack}, {1'b1, 16'h1234, OWN_NONE, 1'b0});
        end
        dm_req = 1'b0; mem_ready = 1'b0;
        step();
        total++;
        if ({owner, mem_addr, dm_ack} !== {OWN_IF, 16'h0040, 1'b0}) begin
            bad++; $display("FAIL contend_if_next: got %h want %h", {owner, mem_addr, dm_ack}, {OWN_IF, 16'h0040, 1'b0});
        end
        mem_ready = 1'b1; mem_rdata = 16'h5678;
        step();
        total++;
        if ({if_ack, if_rdata, dm_ack} !== {1'b1, 16'h5678, 1'b0}) begin
            bad++; $display("FAIL contend_if_ack: got %h want %h", {if_ack, if_rdata, dm_ack}, {1'b1, 16'h5678, 1'b0});
        end
        if_req = 1'b0; mem_ready = 1'b0;
        step();
        total++;
        if ({owner, mem_req} !== {OWN_NONE, 1'b0}) begin
            bad++; $display("FAIL contend_no_regrant: got %h want 0", {owner, mem_req});
        end
    endtask

    task automatic test_store();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0300; dm_wdata = 16'hBEEF;
        mem_ready = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, if_ack} !== {1'b1, 1'b1, 16'h0300, 16'hBEEF, 1'b0}) begin
                bad++; $display("FAIL store_hold: got %h want %h", {mem_req, mem_we, mem_addr, mem_wdata, if_ack}, {1'b1, 1'b1, 16'h0300, 16'hBEEF, 1'b0});
            end
            step();
        end
        mem_ready = 1'b1; mem_rdata = 16'h0BAD;
        step();
        total++;
        if ({dm_ack, if_ack, mem_req} !== {1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL store_ack: got %b want 100", {dm_ack, if_ack, mem_req});
        end
        dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        int  dm_acks;
        bit  if_won, done;
        dm_acks = 0; if_won = 1'b0; done = 1'b0;
        mem_ready = 1'b1; mem_rdata = 16'h7777;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0500; if_addr = 16'h0600;
        for (int n = 0; n < 80 && !done; n++) begin
            if (!if_won) if_req = !dm_ack;
            step();
            if (dm_ack && !if_won) dm_acks++;
            if (owner == OWN_IF) if_won = 1'b1;
            if (if_ack) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL starve_if_ack: got no if_ack want if_ack within 80 cycles");
        end
        total++;
        if (dm_acks != SL) begin
            bad++; $display("FAIL starve_dm_count: got %0d want %0d", dm_acks, SL);
        end
        if_req = 1'b0;
        step();
        step();
        dm_req = 1'b0;
        step();
        total++;
        if (dut.starve_r !== 3'd0) begin
            bad++; $display("FAIL starve_cleared: got %0d want 0", dut.starve_r);
        end
        total++;
        if (dut_vec() !== mdl_vec()) begin
            bad++; $display("FAIL starve_model: got %h want %h", dut_vec(), mdl_vec());
        end
        mem_ready = 1'b0;
        step();
    endtask

    task automatic test_ready_at_limit();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0700; mem_ready = 1'b0;
        step();
        for (int k = 0; k < TO - 1; k++) step();
        total++;
        if ({dm_ack, mem_req} !== 2'b01) begin
            bad++; $display("FAIL limit_still_busy: got %b want 01", {dm_ack, mem_req});
        end
        mem_ready = 1'b1; mem_rdata = 16'h4242;
        step();
        total++;
        if ({dm_ack, dm_rdata, bus_err} !== {1'b1, 16'h4242, 1'b0}) begin
            bad++; $display("FAIL limit_ready_wins: got %h want %h", {dm_ack, dm_rdata, bus_err}, {1'b1, 16'h4242, 1'b0});
        end
        dm_req = 1'b0; mem_ready = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0400; mem_ready = 1'b0;
        step();
        for (int k = 0; k < TO - 1; k++) begin
            step();
            total++;
            if ({dm_ack, mem_req, bus_err} !== 3'b010) begin
                bad++; $display("FAIL timeout_early: cycle %0d got %b want 010", k, {dm_ack, mem_req, bus_err});
            end
        end
        step();
        total++;
        if ({dm_ack, dm_rdata, bus_err, mem_req} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
            bad++; $display("FAIL timeout_abort: got %h want %h", {dm_ack, dm_rdata, bus_err, mem_req}, {1'b1, 16'h0000, 1'b1, 1'b0});
        end
        dm_req = 1'b0;
        if_req = 1'b1; if_addr = 16'h0011; mem_ready = 1'b1; mem_rdata = 16'h0F0F;
        step();
        step();
        total++;
        if ({if_ack, if_rdata, bus_err} !== {1'b1, 16'h0F0F, 1'b1}) begin
            bad++; $display("FAIL timeout_sticky: got %h want %h", {if_ack, if_rdata, bus_err}, {1'b1, 16'h0F0F, 1'b1});
        end
        if_req = 1'b0; mem_ready = 1'b0;
        step();
    endtask

    task automatic test_rst_mid();
        if_req = 1'b1; if_addr = 16'h0022; mem_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        total++;
        if ({mem_req, owner, if_ack, bus_err} !== 5'b0) begin
            bad++; $display("FAIL rst_mid: got %b want 00000", {mem_req, owner, if_ack, bus_err});
        end
        rst = 1'b0;
        step();
        mem_ready = 1'b1; mem_rdata = 16'h3C3C;
        step();
        total++;
        if ({if_ack, if_rdata, owner} !== {1'b1, 16'h3C3C, OWN_NONE}) begin
            bad++; $display("FAIL rst_rerequest: got %h want %h", {if_ack, if_rdata, owner}, {1'b1, 16'h3C3C, OWN_NONE});
        end
        if_req = 1'b0; mem_ready = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000 && bad < 20; n++) begin
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++; $display("FAIL random cycle %0d: got %h want %h", n, dut_vec(), mdl_vec());
            end
            if (if_req && if_ack) begin
                if ($urandom_range(1) == 0) if_req = 1'b0;
            end else if (!if_req && $urandom_range(2) == 0) begin
                if_req = 1'b1; if_addr = 16'($urandom);
            end
            if (dm_req && dm_ack) begin
                if ($urandom_range(1) == 0) dm_req = 1'b0;
            end else if (!dm_req && $urandom_range(2) == 0) begin
                dm_req = 1'b1; dm_we = 1'($urandom_range(1));
                dm_addr = 16'($urandom); dm_wdata = 16'($urandom);
            end
            mem_ready = ($urandom_range(2) == 0);
            mem_rdata = 16'($urandom);
            rst = ($urandom_range(249) == 0);
            step();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
        if_addr = 16'h0; dm_addr = 16'h0; dm_wdata = 16'h0; mem_rdata = 16'h0;
        model_reset();
        test_reset();
        test_if_only();
        test_contend();
        test_store();
        test_starvation();
        test_ready_at_limit();
        test_timeout();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
